// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte-wide target on the CPU external bus.
// It decodes one address window (addr[21:ADDR_W] == BASE, mem_io == IS_MEM) and stretches the
// cycle with WAIT_STATES pad_wait cycles. Reads come from an internal RAM and writes commit to it.
//
// Ports:
//   clk, arst_n      clock (rising edge) and asynchronous active-low reset
//   addr[21:0]       CPU address
//   data_in[7:0]     CPU write data
//   rd, wr           read / write strobes, active high
//   mem_io           space select
//   data_out[7:0]    read data; holds its last value while data_oe is low
//   data_oe          read data valid and driven
//   pad_wait         stall request to the CPU
//   bus_err          one-cycle pulse on a protocol violation
//
// Optional feature: define MEM_RESP_ROM_LOCK_EN to write-protect offsets below ROM_BYTES.
// A locked write is dropped, and bus_err pulses in its access cycle.
//
// Timing: pad_wait is high for exactly WAIT_STATES cycles, starting with the strobe cycle.
// The access (read data valid, or write commit edge) happens in cycle WAIT_STATES. The IDLE
// cycle counts as the first wait cycle, so WAIT lasts WAIT_STATES-1 cycles. With
// WAIT_STATES == 0 the access happens in the strobe cycle itself, straight out of IDLE.
module mem_bus_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned BASE        = 0,
  parameter int unsigned WAIT_STATES = 2,
  parameter bit          IS_MEM      = 1'b1,
  parameter int unsigned ROM_BYTES   = 256
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [21:0] addr,
  input  logic [7:0]  data_in,
  input  logic        rd,
  input  logic        wr,
  input  logic        mem_io,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        pad_wait,
  output logic        bus_err
);

  localparam int unsigned       HiW    = 22 - ADDR_W;
  localparam logic [HiW-1:0]    BaseV  = HiW'(BASE);
  localparam logic [3:0]        WsLoad = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StHold} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              dir_wr_q;
  logic [7:0]        data_q;
  logic [7:0]        mem [2**ADDR_W];

  logic              sel, strobe, in_idle, idle_access, access;
  logic              acc_wr, rom_hit, commit, cur_strobe, other_strobe;
  logic              err_both, err_dir, err_rom;
  logic [ADDR_W-1:0] off, acc_off;
  logic [7:0]        rd_data;

  assign off     = addr[ADDR_W-1:0];
  assign sel     = (mem_io == IS_MEM) && (addr[21:ADDR_W] == BaseV);
  assign strobe  = sel && (rd ^ wr);
  assign in_idle = (state_q == StIdle);

  // Zero-wait accesses are served directly from IDLE using the live address and direction.
  assign idle_access = in_idle && strobe && (WAIT_STATES == 0);
  assign access      = idle_access || (state_q == StAccess);
  assign acc_off     = idle_access ? off : addr_q;
  assign acc_wr      = idle_access ? wr  : dir_wr_q;

`ifdef MEM_RESP_ROM_LOCK_EN
  assign rom_hit = 32'(acc_off) < ROM_BYTES;
`else
  assign rom_hit = 1'b0;
`endif

  // The arst_n term keeps a write from landing at an edge that occurs while reset is held.
  assign commit = arst_n && access && acc_wr && !rom_hit;

  // The strobe for the latched direction, and the opposite one.
  assign cur_strobe   = dir_wr_q ? wr : rd;
  assign other_strobe = dir_wr_q ? rd : wr;

  assign err_both = in_idle && sel && rd && wr;
  assign err_dir  = ((state_q == StWait) || (state_q == StHold)) && other_strobe;
  assign err_rom  = access && acc_wr && rom_hit;

  // Outputs are combinational on state; gating with arst_n forces them low during reset
  // even while the CPU still drives a strobe.
  assign bus_err  = arst_n && (err_both || err_dir || err_rom);
  assign pad_wait = arst_n && ((in_idle && strobe && (WAIT_STATES != 0)) ||
                               (state_q == StWait));
  assign data_oe  = arst_n && ((access && !acc_wr) || ((state_q == StHold) && !dir_wr_q));
  assign rd_data  = mem[acc_off];
  assign data_out = data_oe ? rd_data : data_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      dir_wr_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      if (data_oe) data_q <= rd_data;
      unique case (state_q)
        StIdle: begin
          if (strobe) begin
            addr_q   <= off;
            dir_wr_q <= wr;
            if (WAIT_STATES == 0) begin
              state_q <= StHold;
            end else if (WAIT_STATES == 1) begin
              state_q <= StAccess;
            end else begin
              cnt_q   <= WsLoad;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (other_strobe || !(sel && cur_strobe)) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= StAccess;
          end
        end
        StAccess: state_q <= StHold;
        StHold: begin
          if ((!rd && !wr) || other_strobe) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (commit) mem[acc_off] <= data_in;
  end

endmodule
